alu_op_issuer: RTL and testbench

//  Producer side of the ALU control interface. Accepts decoded ops on a valid/ready port, encodes

---
 rtl/alu_op_issuer_pkg.sv | 34 +++
 rtl/alu_op_issuer_if.sv | 51 +++++
 rtl/alu_op_issuer_alu_opcode_encoder.sv | 33 +++
 rtl/alu_op_issuer.sv | 136 +++++++++++++
 tb/tb_alu_op_issuer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU op issuer: function codes, ALU opcodes and FSM states.
package alu_op_issuer_pkg;

  typedef enum logic [3:0] {
    FnAdd = 4'd0,
    FnSub = 4'd1,
    FnAnd = 4'd2,
    FnOr  = 4'd3,
    FnSll = 4'd4,
    FnSra = 4'd5,
    FnMul = 4'd6,
    FnDiv = 4'd7
  } func_e;

  localparam logic [4:0] OpcAdd = 5'b00000;
  localparam logic [4:0] OpcSub = 5'b00001;
  localparam logic [4:0] OpcAnd = 5'b00010;
  localparam logic [4:0] OpcOr  = 5'b00011;
  localparam logic [4:0] OpcSll = 5'b00100;
  localparam logic [4:0] OpcSra = 5'b00101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExec   = 2'd1,
    StWaitMd = 2'd2,
    StResp   = 2'd3
  } state_e;

  // Only ADD/SUB report ALU overflow; the ALU's flag is meaningless for other ops.
  function automatic logic is_addsub(logic [3:0] func);
    return (func == FnAdd) || (func == FnSub);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Bundle of decode-side, ALU, multdiv and result-side signals around the ALU op issuer.
interface alu_op_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [4:0]  in_shamt;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        overflow;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_exception;

  // Issuer side.
  modport master (
    input  in_valid, in_func, in_shamt, in_a, in_b,
    output in_ready,
    output ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    input  data_result, overflow,
    output ctrl_MULT, ctrl_DIV,
    input  md_result, md_exception, md_resultRDY,
    output out_valid, out_result, out_exception,
    input  out_ready
  );

  // Environment side: decode, ALU, multdiv and result consumer.
  modport slave (
    output in_valid, in_func, in_shamt, in_a, in_b,
    input  in_ready,
    input  ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    output data_result, overflow,
    input  ctrl_MULT, ctrl_DIV,
    output md_result, md_exception, md_resultRDY,
    input  out_valid, out_result, out_exception,
    output out_ready
  );
endinterface

// File: rtl/alu_op_issuer_alu_opcode_encoder.sv
// Combinational decode of a function code into ALU opcode and multdiv/illegal flags.
module alu_opcode_encoder
  import alu_op_issuer_pkg::*;
(
  input  logic [3:0] func_i,
  output logic [4:0] opcode_o,
  output logic       is_md_o,
  output logic       is_mul_o,
  output logic       illegal_o
);

  always_comb begin
    opcode_o  = OpcAdd;
    is_md_o   = 1'b0;
    is_mul_o  = 1'b0;
    illegal_o = 1'b0;
    case (func_i)
      FnAdd: opcode_o = OpcAdd;
      FnSub: opcode_o = OpcSub;
      FnAnd: opcode_o = OpcAnd;
      FnOr:  opcode_o = OpcOr;
      FnSll: opcode_o = OpcSll;
      FnSra: opcode_o = OpcSra;
      FnMul: begin
        is_md_o  = 1'b1;
        is_mul_o = 1'b1;
      end
      FnDiv: is_md_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues decoded ops to the ALU or multdiv unit and returns one result per op.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int unsigned MdTimeout = 64,
  parameter int unsigned CntW      = 7
) (
  input  logic              clock,
  input  logic              reset,
  alu_op_issuer_if.master   bus
);

  logic [4:0] enc_opcode;
  logic       enc_is_md;
  logic       enc_is_mul;
  logic       enc_illegal;

  alu_opcode_encoder u_encoder (
    .func_i    (bus.in_func),
    .opcode_o  (enc_opcode),
    .is_md_o   (enc_is_md),
    .is_mul_o  (enc_is_mul),
    .illegal_o (enc_illegal)
  );

  state_e            state_q;
  logic              in_ready_q;
  logic [4:0]        opcode_q;
  logic [4:0]        shamt_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;
  logic              is_md_q;
  logic              addsub_q;
  logic              mult_q;
  logic              div_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_d;
  logic              out_valid_q;
  logic [31:0]       result_q;
  logic              exc_q;

  assign cnt_d = cnt_q + CntW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      opcode_q    <= OpcAdd;
      shamt_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      is_md_q     <= 1'b0;
      addsub_q    <= 1'b0;
      mult_q      <= 1'b0;
      div_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
    end else begin
      mult_q <= 1'b0;
      div_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (enc_illegal) begin
              // Operand regs left alone so the ALU inputs do not move.
              result_q    <= '0;
              exc_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              opcode_q <= enc_opcode;
              shamt_q  <= bus.in_shamt;
              op_a_q   <= bus.in_a;
              op_b_q   <= bus.in_b;
              is_md_q  <= enc_is_md;
              addsub_q <= is_addsub(bus.in_func);
              mult_q   <= enc_is_md & enc_is_mul;
              div_q    <= enc_is_md & ~enc_is_mul;
              state_q  <= StExec;
            end
          end
        end
        StExec: begin
          if (is_md_q) begin
            cnt_q   <= '0;
            state_q <= StWaitMd;
          end else begin
            result_q    <= bus.data_result;
            exc_q       <= addsub_q & bus.overflow;
            out_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StWaitMd: begin
          cnt_q <= cnt_d;
          if (bus.md_resultRDY) begin
            result_q    <= bus.md_result;
            exc_q       <= bus.md_exception;
            out_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_d == CntW'(MdTimeout)) begin
            result_q    <= '0;
            exc_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.ctrl_ALUopcode = opcode_q;
  assign bus.ctrl_shiftamt  = shamt_q;
  assign bus.data_operandA  = op_a_q;
  assign bus.data_operandB  = op_b_q;
  assign bus.ctrl_MULT      = mult_q;
  assign bus.ctrl_DIV       = div_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = result_q;
  assign bus.out_exception  = exc_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed self-checking bench for alu_op_issuer with a behavioural ALU on the far side.
module tb_alu_op_issuer;

  localparam int unsigned MdTimeout = 64;

  logic clk;
  logic reset;
  logic ovf_force;
  logic [31:0] alu_res;
  logic alu_ovf;
  int errors;
  int checks;

  alu_op_issuer_if ifc ();

  alu_op_issuer #(
    .MdTimeout (MdTimeout),
    .CntW      (7)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: combinational from the issuer's registered controls.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ifc.ctrl_ALUopcode)
      5'b00000: begin
        alu_res = ifc.data_operandA + ifc.data_operandB;
        alu_ovf = (ifc.data_operandA[31] == ifc.data_operandB[31]) &&
                  (alu_res[31] != ifc.data_operandA[31]);
      end
      5'b00001: begin
        alu_res = ifc.data_operandA - ifc.data_operandB;
        alu_ovf = (ifc.data_operandA[31] != ifc.data_operandB[31]) &&
                  (alu_res[31] != ifc.data_operandA[31]);
      end
      5'b00010: alu_res = ifc.data_operandA & ifc.data_operandB;
      5'b00011: alu_res = ifc.data_operandA | ifc.data_operandB;
      5'b00100: alu_res = ifc.data_operandA << ifc.ctrl_shiftamt;
      5'b00101: alu_res = $signed(ifc.data_operandA) >>> ifc.ctrl_shiftamt;
      default:  alu_res = '0;
    endcase
  end

  assign ifc.data_result = alu_res;
  assign ifc.overflow    = alu_ovf | ovf_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single cycle; returns just after the accepting edge.
  task automatic issue(input logic [3:0] func, input logic [4:0] shamt,
                       input logic [31:0] a, input logic [31:0] b);
    ifc.in_valid = 1'b1;
    ifc.in_func  = func;
    ifc.in_shamt = shamt;
    ifc.in_a     = a;
    ifc.in_b     = b;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 0 0",
               ifc.in_ready, ifc.out_valid);
    end
    checks++;
    if (ifc.ctrl_ALUopcode !== 5'b0 || ifc.data_operandA !== 32'h0 ||
        ifc.data_operandB !== 32'h0 || ifc.ctrl_MULT !== 1'b0 || ifc.ctrl_DIV !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: opc=%b a=%h b=%h mult=%b div=%b want all 0",
               ifc.ctrl_ALUopcode, ifc.data_operandA, ifc.data_operandB,
               ifc.ctrl_MULT, ifc.ctrl_DIV);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", ifc.in_ready);
    end
  endtask

  task automatic test_add();
    ifc.out_ready = 1'b1;
    issue(4'd0, 5'd0, 32'd7, 32'd5);
    checks++;
    if (ifc.ctrl_ALUopcode !== 5'b00000 || ifc.data_operandA !== 32'd7 ||
        ifc.data_operandB !== 32'd5 || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_exec: opc=%b a=%h b=%h rdy=%b ov=%b want 00000 7 5 0 0",
               ifc.ctrl_ALUopcode, ifc.data_operandA, ifc.data_operandB,
               ifc.in_ready, ifc.out_valid);
    end
    tick();
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'd12 || ifc.out_exception !== 1'b0) begin
      errors++;
      $display("FAIL add_result: ov=%b res=%h exc=%b want 1 0000000c 0",
               ifc.out_valid, ifc.out_result, ifc.out_exception);
    end
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_return_idle: rdy=%b ov=%b want 1 0", ifc.in_ready, ifc.out_valid);
    end
  endtask

  task automatic test_or_hold();
    ifc.out_ready = 1'b0;
    issue(4'd3, 5'd0, 32'hF0, 32'h0F);
    checks++;
    if (ifc.ctrl_ALUopcode !== 5'b00011) begin
      errors++;
      $display("FAIL or_opcode: got %b want 00011", ifc.ctrl_ALUopcode);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'hFF || ifc.in_ready !== 1'b0 ||
          ifc.ctrl_ALUopcode !== 5'b00011) begin
        errors++;
        $display("FAIL or_hold[%0d]: ov=%b res=%h rdy=%b opc=%b want 1 000000ff 0 00011",
                 i, ifc.out_valid, ifc.out_result, ifc.in_ready, ifc.ctrl_ALUopcode);
      end
      tick();
    end
    ifc.out_ready = 1'b1;
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL or_release: rdy=%b ov=%b want 1 0", ifc.in_ready, ifc.out_valid);
    end
  endtask

  task automatic test_sub_overflow();
    issue(4'd1, 5'd0, 32'h8000_0000, 32'd1);
    checks++;
    if (ifc.ctrl_ALUopcode !== 5'b00001) begin
      errors++;
      $display("FAIL sub_opcode: got %b want 00001", ifc.ctrl_ALUopcode);
    end
    tick();
    checks++;
    if (ifc.out_result !== 32'h7FFF_FFFF || ifc.out_exception !== 1'b1) begin
      errors++;
      $display("FAIL sub_overflow: res=%h exc=%b want 7fffffff 1",
               ifc.out_result, ifc.out_exception);
    end
    tick();
  endtask

  task automatic test_shift_no_overflow();
    ovf_force = 1'b1;
    issue(4'd4, 5'd4, 32'd1, 32'd0);
    checks++;
    if (ifc.ctrl_ALUopcode !== 5'b00100 || ifc.ctrl_shiftamt !== 5'd4) begin
      errors++;
      $display("FAIL sll_ctrl: opc=%b shamt=%0d want 00100 4",
               ifc.ctrl_ALUopcode, ifc.ctrl_shiftamt);
    end
    tick();
    checks++;
    if (ifc.out_result !== 32'd16 || ifc.out_exception !== 1'b0) begin
      errors++;
      $display("FAIL sll_result: res=%h exc=%b want 00000010 0",
               ifc.out_result, ifc.out_exception);
    end
    tick();
    ovf_force = 1'b0;
  endtask

  task automatic test_mul();
    int pulses;
    int early;
    pulses = 0;
    early  = 0;
    issue(4'd6, 5'd0, 32'd3, 32'd4);
    checks++;
    if (ifc.ctrl_MULT !== 1'b1 || ifc.ctrl_DIV !== 1'b0 || ifc.ctrl_ALUopcode !== 5'b00000) begin
      errors++;
      $display("FAIL mul_start: mult=%b div=%b opc=%b want 1 0 00000",
               ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.ctrl_ALUopcode);
    end
    // RDY during EXEC must be ignored.
    ifc.md_resultRDY = 1'b1;
    ifc.md_result    = 32'd99;
    tick();
    ifc.md_resultRDY = 1'b0;
    ifc.md_result    = 32'hDEAD_BEEF;
    for (int i = 0; i < 9; i++) begin
      if (ifc.ctrl_MULT === 1'b1) pulses++;
      if (ifc.out_valid === 1'b1) early++;
      tick();
    end
    checks++;
    if (pulses != 0 || early != 0) begin
      errors++;
      $display("FAIL mul_wait: extra_pulses=%0d early_valid=%0d want 0 0", pulses, early);
    end
    ifc.md_resultRDY = 1'b1;
    ifc.md_result    = 32'd12;
    tick();
    ifc.md_resultRDY = 1'b0;
    ifc.md_result    = 32'h0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'd12 || ifc.out_exception !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: ov=%b res=%h exc=%b want 1 0000000c 0",
               ifc.out_valid, ifc.out_result, ifc.out_exception);
    end
    tick();
  endtask

  task automatic test_div_timeout();
    int early;
    early = 0;
    issue(4'd7, 5'd0, 32'd10, 32'd0);
    checks++;
    if (ifc.ctrl_DIV !== 1'b1 || ifc.ctrl_MULT !== 1'b0) begin
      errors++;
      $display("FAIL div_start: div=%b mult=%b want 1 0", ifc.ctrl_DIV, ifc.ctrl_MULT);
    end
    for (int i = 0; i < int'(MdTimeout); i++) begin
      tick();
      if (ifc.out_valid === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL div_wait: early_valid=%0d want 0", early);
    end
    tick();
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'h0 || ifc.out_exception !== 1'b1) begin
      errors++;
      $display("FAIL div_timeout: ov=%b res=%h exc=%b want 1 00000000 1",
               ifc.out_valid, ifc.out_result, ifc.out_exception);
    end
    tick();
  endtask

  task automatic test_rdy_at_timeout();
    issue(4'd7, 5'd0, 32'd20, 32'd4);
    for (int i = 0; i < int'(MdTimeout); i++) tick();
    ifc.md_resultRDY = 1'b1;
    ifc.md_result    = 32'h55;
    ifc.md_exception = 1'b0;
    tick();
    ifc.md_resultRDY = 1'b0;
    ifc.md_result    = 32'h0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'h55 || ifc.out_exception !== 1'b0) begin
      errors++;
      $display("FAIL rdy_beats_timeout: ov=%b res=%h exc=%b want 1 00000055 0",
               ifc.out_valid, ifc.out_result, ifc.out_exception);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(4'd9, 5'd3, 32'hFFFF, 32'hFFFF);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'h0 || ifc.out_exception !== 1'b1 ||
        ifc.ctrl_MULT !== 1'b0 || ifc.ctrl_DIV !== 1'b0 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_func: ov=%b res=%h exc=%b mult=%b div=%b rdy=%b want 1 0 1 0 0 0",
               ifc.out_valid, ifc.out_result, ifc.out_exception,
               ifc.ctrl_MULT, ifc.ctrl_DIV, ifc.in_ready);
    end
    tick();
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_return: rdy=%b want 1", ifc.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    ifc.in_valid = 1'b1;
    ifc.in_func  = 4'd0;
    ifc.in_a     = 32'd100;
    ifc.in_b     = 32'd1;
    tick();
    ifc.in_a = 32'd200;
    ifc.in_b = 32'd2;
    tick();
    checks++;
    if (ifc.out_result !== 32'd101 || ifc.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: ov=%b res=%h want 1 00000065", ifc.out_valid, ifc.out_result);
    end
    tick();
    tick();
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.data_operandA !== 32'd200 || ifc.ctrl_ALUopcode !== 5'b00000) begin
      errors++;
      $display("FAIL b2b_second_accept: a=%h opc=%b want 000000c8 00000",
               ifc.data_operandA, ifc.ctrl_ALUopcode);
    end
    tick();
    checks++;
    if (ifc.out_result !== 32'd202 || ifc.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: ov=%b res=%h want 1 000000ca", ifc.out_valid, ifc.out_result);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int stray;
    stray = 0;
    issue(4'd6, 5'd0, 32'd5, 32'd6);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.ctrl_MULT !== 1'b0 || ifc.ctrl_ALUopcode !== 5'b0 ||
        ifc.data_operandA !== 32'h0) begin
      errors++;
      $display("FAIL reset_wait_clear: ov=%b mult=%b opc=%b a=%h want 0 0 00000 0",
               ifc.out_valid, ifc.ctrl_MULT, ifc.ctrl_ALUopcode, ifc.data_operandA);
    end
    ifc.md_resultRDY = 1'b1;
    ifc.md_result    = 32'd77;
    tick();
    ifc.md_resultRDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ifc.out_valid === 1'b1) stray++;
      tick();
    end
    checks++;
    if (stray != 0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_idle: stray_valid=%0d rdy=%b want 0 1", stray, ifc.in_ready);
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    reset            = 1'b1;
    ovf_force        = 1'b0;
    ifc.in_valid     = 1'b0;
    ifc.in_func      = 4'd0;
    ifc.in_shamt     = 5'd0;
    ifc.in_a         = 32'h0;
    ifc.in_b         = 32'h0;
    ifc.md_result    = 32'h0;
    ifc.md_exception = 1'b0;
    ifc.md_resultRDY = 1'b0;
    ifc.out_ready    = 1'b1;

    test_reset();
    test_add();
    test_or_hold();
    test_sub_overflow();
    test_shift_no_overflow();
    test_mul();
    test_div_timeout();
    test_rdy_at_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_in_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
